// File: rtl/instr_encoder_if.sv
// Instruction-field input handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, mnem, rs, rt, rd, shamt, imm, target,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, shamt, imm, target,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes mnemonic/field tuples into MIPS words and streams them into instruction memory.
// One-cycle write latency; in_ready drops once finish is seen or the last address is used.
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                finish,
  instr_encoder_if.slave      bus,
  output logic [ADDR_W:0]     count,
  output logic                err,
  output logic                full,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic              closing;
  logic              hit_last;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ready;
  logic              xfer;
  logic              legal;
  logic              wr_go;
  logic [31:0]       enc;
  logic [5:0]        func;

  assign ready          = (state == RUN) && !full && !closing;
  assign xfer           = bus.in_valid && ready;
  assign legal          = (bus.mnem < 5'd28);
  assign wr_go          = xfer && legal;
  assign bus.in_ready   = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  always_comb begin
    func = 6'd0;
    case (bus.mnem)
      5'd1:    func = 6'd3;
      5'd2:    func = 6'd2;
      5'd3:    func = 6'd32;
      5'd4:    func = 6'd33;
      5'd5:    func = 6'd34;
      5'd6:    func = 6'd36;
      5'd7:    func = 6'd37;
      5'd8:    func = 6'd39;
      5'd9:    func = 6'd42;
      5'd10:   func = 6'd43;
      5'd13:   func = 6'd38;
      default: func = 6'd0;
    endcase
  end

  // Shifts take their source from rt and ignore rs; other R-types ignore shamt.
  always_comb begin
    enc = 32'd0;
    case (bus.mnem)
      5'd0, 5'd1, 5'd2:
        enc = {6'd0, 5'd0, bus.rt, bus.rd, bus.shamt, func};
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd13:
        enc = {6'd0, bus.rs, bus.rt, bus.rd, 5'd0, func};
      5'd11:   enc = {6'd0, bus.rs, 15'd0, 6'd8};
      5'd12:   enc = 32'h0000_000C;
      5'd14:   enc = {6'd1, bus.rs, 5'd1, bus.imm};
      5'd15:   enc = {6'd2, bus.target};
      5'd16:   enc = {6'd3, bus.target};
      5'd17:   enc = {6'd4,  bus.rs, bus.rt, bus.imm};
      5'd18:   enc = {6'd5,  bus.rs, bus.rt, bus.imm};
      5'd19:   enc = {6'd8,  bus.rs, bus.rt, bus.imm};
      5'd20:   enc = {6'd12, bus.rs, bus.rt, bus.imm};
      5'd21:   enc = {6'd9,  bus.rs, bus.rt, bus.imm};
      5'd22:   enc = {6'd10, bus.rs, bus.rt, bus.imm};
      5'd23:   enc = {6'd13, bus.rs, bus.rt, bus.imm};
      5'd24:   enc = {6'd14, bus.rs, bus.rt, bus.imm};
      5'd25:   enc = {6'd37, bus.rs, bus.rt, bus.imm};
      5'd26:   enc = {6'd35, bus.rs, bus.rt, bus.imm};
      5'd27:   enc = {6'd43, bus.rs, bus.rt, bus.imm};
      default: enc = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (closing || (finish && !wr_go)) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // closing marks a session whose final write is in flight; DONE follows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      count    <= '0;
      err      <= 1'b0;
      full     <= 1'b0;
      done     <= 1'b0;
      closing  <= 1'b0;
      hit_last <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
    end else begin
      we_q <= 1'b0;
      if (state != RUN) begin
        if (start) begin
          ptr      <= base_addr;
          count    <= '0;
          err      <= 1'b0;
          full     <= 1'b0;
          done     <= 1'b0;
          closing  <= 1'b0;
          hit_last <= 1'b0;
        end
      end else if (closing) begin
        done    <= 1'b1;
        full    <= hit_last;
        closing <= 1'b0;
      end else begin
        if (wr_go) begin
          we_q    <= 1'b1;
          addr_q  <= ptr;
          wdata_q <= enc;
          count   <= count + 1'b1;
          if (&ptr) begin
            closing  <= 1'b1;
            hit_last <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        if (xfer && !legal) err <= 1'b1;
        if (finish) begin
          if (wr_go) closing <= 1'b1;
          else       done    <= 1'b1;
        end
      end
    end
  end

endmodule
